// File: rtl/cceip_inbound_sched.sv
// Job sequencer for cceip_inbound: launches the datapath, splits the host buffer into
// boundary-aligned read commands under an outstanding-data cap, and reports completion.
module cceip_inbound_sched #(
    parameter int unsigned C_ADDR_WIDTH      = 64,
    parameter int unsigned C_DATA_BYTES      = 8,
    parameter int unsigned C_MAX_XFER_BYTES  = 4096,
    parameter int unsigned C_MAX_OUTSTANDING = 4
) (
    input  logic                    ap_clk,
    input  logic                    areset,
    input  logic                    ctrl_start,
    input  logic [C_ADDR_WIDTH-1:0] ctrl_addr,
    input  logic [63:0]             ctrl_size,
    output logic                    ctrl_busy,
    output logic                    ctrl_done,
    output logic                    ctrl_error,
    output logic                    inbound_start,
    output logic [63:0]             input_data_size,
    output logic                    rd_cmd_valid,
    input  logic                    rd_cmd_ready,
    output logic [C_ADDR_WIDTH-1:0] rd_cmd_addr,
    output logic [31:0]             rd_cmd_bytes,
    input  logic                    mm_beat_valid,
    input  logic                    mm_beat_ready
);
    localparam int unsigned DB_LOG = $clog2(C_DATA_BYTES);
    localparam logic [63:0] DMASK  = 64'(C_DATA_BYTES - 1);
    localparam logic [63:0] XMASK  = 64'(C_MAX_XFER_BYTES - 1);
    localparam logic [63:0] XFER   = 64'(C_MAX_XFER_BYTES);
    localparam logic [63:0] CREDIT = 64'(C_MAX_OUTSTANDING) * XFER;

    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_ISSUE, S_DRAIN, S_FIN, S_ERR} state_t;
    state_t state;

    logic [C_ADDR_WIDTH-1:0] cur_addr, addr_nx;
    logic [63:0] remaining, rem_nx, job_size, total_beats;
    logic [63:0] issued_bytes, issued_nx, beat_count, beat_count_nx;
    logic [63:0] consumed, room, nxt_bytes;
    logic        handshake, credit_ok;

    always_comb begin
        handshake = rd_cmd_valid && rd_cmd_ready;
        addr_nx   = cur_addr;
        rem_nx    = remaining;
        issued_nx = issued_bytes;
        if (handshake) begin
            addr_nx   = cur_addr + C_ADDR_WIDTH'(rd_cmd_bytes);
            rem_nx    = remaining - 64'(rd_cmd_bytes);
            issued_nx = issued_bytes + 64'(rd_cmd_bytes);
        end
        room      = XFER - (64'(addr_nx) & XMASK);
        nxt_bytes = (rem_nx < room) ? rem_nx : room;
        // Saturating via the beat count avoids overflow of beats*C_DATA_BYTES near 2^64.
        consumed  = (beat_count >= total_beats) ? job_size : (beat_count << DB_LOG);
        credit_ok = (consumed >= issued_nx) || ((issued_nx - consumed) < CREDIT);
        beat_count_nx = beat_count;
        if (mm_beat_valid && mm_beat_ready && beat_count != total_beats)
            beat_count_nx = beat_count + 64'd1;
    end

    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            state           <= S_IDLE;
            ctrl_busy       <= 1'b0;
            ctrl_done       <= 1'b0;
            ctrl_error      <= 1'b0;
            inbound_start   <= 1'b0;
            input_data_size <= '0;
            rd_cmd_valid    <= 1'b0;
            rd_cmd_addr     <= '0;
            rd_cmd_bytes    <= '0;
            cur_addr        <= '0;
            remaining       <= '0;
            job_size        <= '0;
            total_beats     <= '0;
            issued_bytes    <= '0;
            beat_count      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ctrl_start) begin
                        cur_addr     <= ctrl_addr;
                        remaining    <= ctrl_size;
                        job_size     <= ctrl_size;
                        total_beats  <= (ctrl_size >> DB_LOG) + 64'((ctrl_size & DMASK) != '0);
                        issued_bytes <= '0;
                        beat_count   <= '0;
                        ctrl_busy    <= 1'b1;
                        if ((64'(ctrl_addr) & DMASK) != '0) begin
                            state      <= S_ERR;
                            ctrl_done  <= 1'b1;
                            ctrl_error <= 1'b1;
                        end else if (ctrl_size == '0) begin
                            state     <= S_FIN;
                            ctrl_done <= 1'b1;
                        end else begin
                            state           <= S_LAUNCH;
                            inbound_start   <= 1'b1;
                            input_data_size <= ctrl_size;
                        end
                    end
                end
                S_LAUNCH, S_ISSUE: begin
                    inbound_start <= 1'b0;
                    beat_count    <= beat_count_nx;
                    cur_addr      <= addr_nx;
                    remaining     <= rem_nx;
                    issued_bytes  <= issued_nx;
                    if (state == S_LAUNCH)
                        state <= S_ISSUE;
                    // A presented command that is not yet accepted stays frozen.
                    if (!(rd_cmd_valid && !rd_cmd_ready)) begin
                        if (rem_nx == '0) begin
                            rd_cmd_valid <= 1'b0;
                            state        <= S_DRAIN;
                        end else begin
                            rd_cmd_valid <= credit_ok;
                            rd_cmd_addr  <= addr_nx;
                            rd_cmd_bytes <= 32'(nxt_bytes);
                        end
                    end
                end
                S_DRAIN: begin
                    beat_count <= beat_count_nx;
                    if (beat_count_nx == total_beats) begin
                        state     <= S_FIN;
                        ctrl_done <= 1'b1;
                    end
                end
                S_FIN, S_ERR: begin
                    state      <= S_IDLE;
                    ctrl_done  <= 1'b0;
                    ctrl_error <= 1'b0;
                    ctrl_busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cceip_inbound_sched.sv
// Self-checking bench for cceip_inbound_sched: job-level model plus directed scenarios.
module tb_cceip_inbound_sched;
    localparam int unsigned AW = 64, DB = 8, MX = 4096, MO = 4;
    localparam longint unsigned LIMIT = longint'(MO) * longint'(MX);

    logic          ap_clk = 1'b0;
    logic          areset = 1'b1;
    logic          ctrl_start = 1'b0;
    logic [AW-1:0] ctrl_addr = '0;
    logic [63:0]   ctrl_size = '0;
    logic          ctrl_busy, ctrl_done, ctrl_error, inbound_start;
    logic [63:0]   input_data_size;
    logic          rd_cmd_valid;
    logic          rd_cmd_ready = 1'b0;
    logic [AW-1:0] rd_cmd_addr;
    logic [31:0]   rd_cmd_bytes;
    logic          mm_beat_valid = 1'b0;
    logic          mm_beat_ready = 1'b0;

    always #5 ap_clk = ~ap_clk;

    cceip_inbound_sched #(
        .C_ADDR_WIDTH(AW), .C_DATA_BYTES(DB),
        .C_MAX_XFER_BYTES(MX), .C_MAX_OUTSTANDING(MO)
    ) u_dut (
        .ap_clk(ap_clk), .areset(areset),
        .ctrl_start(ctrl_start), .ctrl_addr(ctrl_addr), .ctrl_size(ctrl_size),
        .ctrl_busy(ctrl_busy), .ctrl_done(ctrl_done), .ctrl_error(ctrl_error),
        .inbound_start(inbound_start), .input_data_size(input_data_size),
        .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready),
        .rd_cmd_addr(rd_cmd_addr), .rd_cmd_bytes(rd_cmd_bytes),
        .mm_beat_valid(mm_beat_valid), .mm_beat_ready(mm_beat_ready)
    );

    int unsigned n_checks = 0, n_pass = 0;
    longint unsigned cyc = 0;
    always @(posedge ap_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    endtask

    typedef struct { logic [63:0] addr; logic [63:0] bytes; } cmd_t;
    cmd_t exp_q[$];
    cmd_t log_q[$];

    // Job-level model state
    bit m_busy = 0, m_done_now = 0, m_err_now = 0, m_launch_now = 0, m_counting = 0;
    longint unsigned m_beats = 0, m_total = 0, m_issued = 0, m_size = 0, m_launch_size = 0;
    bit p_valid = 0, p_ready = 0;
    logic [63:0] p_addr = '0;
    logic [31:0] p_bytes = '0;
    int unsigned done_cnt = 0, launch_cnt = 0;
    longint unsigned start_cyc = 0, done_cyc = 0, first_valid_cyc = 0;

    always @(negedge ap_clk) begin : monitor
        bit n_busy, n_done, n_err, n_launch, beat;
        longint unsigned consumed, a, r, b;
        if (areset) begin
            check("reset_outputs", 64'({ctrl_busy, ctrl_done, ctrl_error, inbound_start, rd_cmd_valid}), 64'd0);
            check("reset_data_size", input_data_size, 64'd0);
            m_busy = 0; m_done_now = 0; m_err_now = 0; m_launch_now = 0; m_counting = 0;
            m_beats = 0; m_issued = 0; m_launch_size = 0;
            p_valid = 0; p_ready = 0;
            exp_q.delete();
        end else begin
            beat = mm_beat_valid && mm_beat_ready;
            check("busy", 64'(ctrl_busy), 64'(m_busy));
            check("done", 64'(ctrl_done), 64'(m_done_now));
            check("error", 64'(ctrl_error), 64'(m_err_now));
            check("inbound_start", 64'(inbound_start), 64'(m_launch_now));
            check("input_data_size", input_data_size, m_launch_size);
            if (ctrl_done) begin done_cnt++; done_cyc = cyc; end
            if (inbound_start) launch_cnt++;
            if (p_valid && !p_ready) begin
                check("hold_valid", 64'(rd_cmd_valid), 64'd1);
                check("hold_addr", rd_cmd_addr, p_addr);
                check("hold_bytes", 64'(rd_cmd_bytes), 64'(p_bytes));
            end
            if (rd_cmd_valid) begin
                consumed = (m_beats * DB > m_size) ? m_size : m_beats * DB;
                check("credit_cap", 64'(m_issued < consumed || (m_issued - consumed) < LIMIT), 64'd1);
                check("cmd_expected", 64'(exp_q.size() != 0 && !m_launch_now), 64'd1);
                if (first_valid_cyc == 0) first_valid_cyc = cyc;
            end
            n_busy = m_busy && !m_done_now;
            n_done = 0; n_err = 0; n_launch = 0;
            if (m_counting && beat) begin
                m_beats++;
                if (m_beats == m_total) begin
                    check("cmds_issued_before_last_beat", 64'(exp_q.size()), 64'd0);
                    m_counting = 0;
                    n_done = 1;
                end
            end
            if (rd_cmd_valid && rd_cmd_ready && exp_q.size() != 0) begin
                check("cmd_addr", rd_cmd_addr, exp_q[0].addr);
                check("cmd_bytes", 64'(rd_cmd_bytes), exp_q[0].bytes);
                m_issued += 64'(rd_cmd_bytes);
                log_q.push_back('{addr: rd_cmd_addr, bytes: 64'(rd_cmd_bytes)});
                void'(exp_q.pop_front());
            end
            if (ctrl_start && !m_busy) begin
                start_cyc = cyc;
                n_busy = 1;
                m_size = ctrl_size; m_beats = 0; m_issued = 0;
                exp_q.delete();
                if (ctrl_addr % 64'(DB) != 0) begin
                    n_done = 1; n_err = 1;
                end else if (ctrl_size == 0) begin
                    n_done = 1;
                end else begin
                    n_launch = 1;
                    m_launch_size = ctrl_size;
                    m_total = (ctrl_size + DB - 1) / DB;
                    m_counting = 1;
                    a = ctrl_addr; r = ctrl_size;
                    while (r > 0) begin
                        b = MX - (a % MX);
                        if (r < b) b = r;
                        exp_q.push_back('{addr: a, bytes: b});
                        a += b; r -= b;
                    end
                end
            end
            m_busy = n_busy; m_done_now = n_done; m_err_now = n_err; m_launch_now = n_launch;
            p_valid = rd_cmd_valid; p_ready = rd_cmd_ready;
            p_addr = rd_cmd_addr; p_bytes = rd_cmd_bytes;
        end
    end

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge ap_clk);
        #1;
    endtask

    task automatic start_job(input logic [63:0] addr, input logic [63:0] size);
        log_q.delete();
        launch_cnt = 0;
        first_valid_cyc = 0;
        ctrl_addr = addr; ctrl_size = size; ctrl_start = 1'b1;
        tick(1);
        ctrl_start = 1'b0;
    endtask

    task automatic wait_done(input int unsigned d0, input int unsigned budget, input string name);
        int unsigned k;
        k = 0;
        while (done_cnt == d0 && k < budget) begin tick(1); k++; end
        check({name, "_done_seen"}, 64'(done_cnt != d0), 64'd1);
    endtask

    task automatic beats(input bit on);
        mm_beat_valid = on; mm_beat_ready = on;
    endtask

    initial begin : stim
        int unsigned d0;
        tick(3);
        areset = 1'b0;
        tick(2);

        // 1: long job, beats every cycle from the launch cycle
        rd_cmd_ready = 1'b1;
        d0 = done_cnt;
        start_job(64'h1000, 64'd114514);
        beats(1);
        check("t1_launch", 64'(inbound_start), 64'd1);
        check("t1_size", input_data_size, 64'd114514);
        wait_done(d0, 20000, "t1");
        beats(0);
        tick(2);
        check("t1_ncmds", 64'(log_q.size()), 64'd28);
        if (log_q.size() == 28) begin
            check("t1_last_addr", log_q[27].addr, 64'h1C000);
            check("t1_last_bytes", log_q[27].bytes, 64'd3922);
        end
        check("t1_done_latency", done_cyc - start_cyc, 64'd14316);
        check("t1_first_cmd_latency", first_valid_cyc - start_cyc, 64'd2);
        check("t1_single_launch", 64'(launch_cnt), 64'd1);

        // 2: job straddling a 4 KiB boundary
        d0 = done_cnt;
        start_job(64'h0FF8, 64'd24);
        tick(4);
        beats(1);
        tick(3);
        beats(0);
        wait_done(d0, 20, "t2");
        check("t2_ncmds", 64'(log_q.size()), 64'd2);
        if (log_q.size() == 2) begin
            check("t2_cmd0_addr", log_q[0].addr, 64'h0FF8);
            check("t2_cmd0_bytes", log_q[0].bytes, 64'd8);
            check("t2_cmd1_addr", log_q[1].addr, 64'h1000);
            check("t2_cmd1_bytes", log_q[1].bytes, 64'd16);
        end
        check("t2_done_latency", done_cyc - start_cyc, 64'd8);

        // 3: outstanding cap
        d0 = done_cnt;
        start_job(64'h20000, 64'd65536);
        tick(30);
        check("t3_capped_ncmds", 64'(log_q.size()), 64'd4);
        check("t3_capped_valid", 64'(rd_cmd_valid), 64'd0);
        beats(1);
        tick(512);
        beats(0);
        tick(3);
        check("t3_after512_ncmds", 64'(log_q.size()), 64'd5);
        if (log_q.size() >= 5) check("t3_cmd4_addr", log_q[4].addr, 64'h24000);
        beats(1);
        wait_done(d0, 10000, "t3");
        beats(0);
        tick(2);

        // 4a: back-pressure holds the command
        rd_cmd_ready = 1'b0;
        d0 = done_cnt;
        start_job(64'h40000, 64'd8192);
        tick(11);
        check("t4_held_valid", 64'(rd_cmd_valid), 64'd1);
        check("t4_held_addr", rd_cmd_addr, 64'h40000);
        check("t4_held_bytes", 64'(rd_cmd_bytes), 64'd4096);
        rd_cmd_ready = 1'b1;
        tick(3);
        beats(1);
        wait_done(d0, 3000, "t4a");
        beats(0);
        tick(2);

        // 4b: zero-size job
        start_job(64'h50000, 64'd0);
        check("t4b_done", 64'(ctrl_done), 64'd1);
        check("t4b_busy", 64'(ctrl_busy), 64'd1);
        check("t4b_no_launch", 64'(inbound_start), 64'd0);
        tick(1);
        check("t4b_idle", 64'(ctrl_busy), 64'd0);

        // 4c: misaligned address
        start_job(64'h1003, 64'd100);
        check("t4c_done_err", 64'({ctrl_done, ctrl_error}), 64'd3);
        tick(3);
        check("t4c_no_cmds", 64'(log_q.size()), 64'd0);
        check("t4c_no_launch", 64'(launch_cnt), 64'd0);

        // 5a: start pulsed mid-job is ignored
        d0 = done_cnt;
        start_job(64'h80000, 64'd16384);
        tick(5);
        ctrl_addr = 64'h90000; ctrl_size = 64'd8; ctrl_start = 1'b1;
        tick(1);
        ctrl_start = 1'b0;
        beats(1);
        wait_done(d0, 5000, "t5a");
        beats(0);
        tick(5);
        check("t5a_one_done", 64'(done_cnt - d0), 64'd1);
        check("t5a_ncmds", 64'(log_q.size()), 64'd4);
        check("t5a_one_launch", 64'(launch_cnt), 64'd1);

        // 5b: reset mid-ISSUE aborts silently, next job runs normally
        rd_cmd_ready = 1'b0;
        d0 = done_cnt;
        start_job(64'hA0000, 64'd65536);
        tick(5);
        areset = 1'b1;
        #1;
        check("t5b_reset_busy", 64'(ctrl_busy), 64'd0);
        check("t5b_reset_valid", 64'(rd_cmd_valid), 64'd0);
        tick(2);
        areset = 1'b0;
        tick(2);
        check("t5b_no_done", 64'(done_cnt), 64'(d0));
        rd_cmd_ready = 1'b1;
        start_job(64'h1000, 64'd64);
        tick(3);
        beats(1);
        wait_done(d0, 50, "t5b");
        beats(0);
        tick(2);
        check("t5b_ncmds", 64'(log_q.size()), 64'd1);
        if (log_q.size() == 1) begin
            check("t5b_cmd_addr", log_q[0].addr, 64'h1000);
            check("t5b_cmd_bytes", log_q[0].bytes, 64'd64);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
